// File: rtl/instr_fetch.sv
// instr_fetch: PC register and variable-latency fetch unit that presents one instruction at a time to decode
// Ports: imem_req/imem_addr strobe a read of the instruction at pc; imem_rdata/imem_rvalid return it.
//   redirect/redirect_pc load a taken branch/jump target and squash any in-flight fetch.
//   instr_valid/instr/instr_op/pc_out/pc_plus4 present the held instruction until dec_ready consumes it.
//   fetch_err is the sticky misaligned-redirect flag.
// Define IFETCH_ALIGN_CHECK_EN to trap misaligned redirects in a FAULT state; otherwise targets are word-aligned.
module instr_fetch #(
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              imem_rvalid,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              dec_ready,
  output logic              instr_valid,
  output logic [31:0]       instr,
  output logic [5:0]        instr_op,
  output logic [ADDR_W-1:0] pc_out,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic              fetch_err
);
  typedef enum logic [2:0] {
    IDLE, REQ, WAIT, HOLD
`ifdef IFETCH_ALIGN_CHECK_EN
    , FAULT
`endif
  } state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, pc_out_q, pc_out_d, tgt;
  logic [31:0] instr_q, instr_d;
  logic squash_q, squash_d;
  assign tgt = redirect_pc & ~ADDR_W'(3);
`ifdef IFETCH_ALIGN_CHECK_EN
  logic fetch_err_q, fetch_err_d;
  assign fetch_err = fetch_err_q;
`else
  assign fetch_err = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    pc_out_d = pc_out_q;
    instr_d = instr_q;
    squash_d = squash_q;
    case (state_q)
      IDLE: begin
        state_d = REQ;
        if (redirect) pc_d = tgt;
      end
      REQ: begin
        state_d = WAIT;
        if (redirect) begin
          pc_d = tgt;
          squash_d = 1'b1;
        end
      end
      WAIT:
        if (redirect) begin
          pc_d = tgt;
          squash_d = !imem_rvalid;
          if (imem_rvalid) state_d = REQ;
        end else if (imem_rvalid) begin
          // a squashed response only retires the stale request; refetch from the new pc
          state_d = squash_q ? REQ : HOLD;
          squash_d = 1'b0;
          if (!squash_q) begin
            instr_d = imem_rdata;
            pc_out_d = pc_q;
          end
        end
      HOLD:
        if (redirect || dec_ready) begin
          pc_d = redirect ? tgt : pc_q + ADDR_W'(4);
          state_d = REQ;
        end
      default: ;
    endcase
`ifdef IFETCH_ALIGN_CHECK_EN
    fetch_err_d = fetch_err_q;
    if (redirect && |redirect_pc[1:0] && state_q != FAULT) begin
      state_d = FAULT;
      fetch_err_d = 1'b1;
    end
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q <= RESET_PC;
      pc_out_q <= RESET_PC;
      instr_q <= '0;
      squash_q <= 1'b0;
`ifdef IFETCH_ALIGN_CHECK_EN
      fetch_err_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      pc_out_q <= pc_out_d;
      instr_q <= instr_d;
      squash_q <= squash_d;
`ifdef IFETCH_ALIGN_CHECK_EN
      fetch_err_q <= fetch_err_d;
`endif
    end
  end
  assign imem_req = state_q == REQ;
  assign imem_addr = pc_q;
  assign instr_valid = state_q == HOLD;
  assign instr = instr_q;
  assign instr_op = instr_q[31:26];
  assign pc_out = pc_out_q;
  assign pc_plus4 = pc_out_q + ADDR_W'(4);
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: scoreboard bench for instr_fetch with a random-latency memory and a program-order reference model
module tb_instr_fetch;
  logic clk = 0, rst = 1;
  logic imem_req, imem_rvalid = 0, redirect = 0, dec_ready = 0, instr_valid, fetch_err;
  logic [31:0] imem_addr, imem_rdata = 0, redirect_pc = 0, instr, pc_out, pc_plus4;
  logic [5:0] instr_op;
  int checks = 0, passed = 0;
  int lat_min = 1, lat_max = 1;
  logic [31:0] m_pc;
  bit m_fault = 0;
  logic [31:0] exp_q[$];
  instr_fetch dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .imem_rvalid(imem_rvalid), .redirect(redirect), .redirect_pc(redirect_pc), .dec_ready(dec_ready),
    .instr_valid(instr_valid), .instr(instr), .instr_op(instr_op), .pc_out(pc_out),
    .pc_plus4(pc_plus4), .fetch_err(fetch_err)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] mem(input logic [31:0] a);
    return a == 0 ? 32'h8C22_0004 : (a * 32'h9E37_79B1) ^ 32'h0F0F_1234;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  // reference model: the architectural fetch pc and the next instruction decode should see
  initial forever begin
    @(posedge clk);
    if (rst) begin
      m_pc = 0;
      m_fault = 0;
      exp_q.delete();
      exp_q.push_back(0);
    end else if (!m_fault) begin
      if (redirect) begin
        exp_q.delete();
`ifdef IFETCH_ALIGN_CHECK_EN
        if (redirect_pc[1:0] != 0) m_fault = 1;
        else begin
          m_pc = redirect_pc;
          exp_q.push_back(m_pc);
        end
`else
        m_pc = {redirect_pc[31:2], 2'b00};
        exp_q.push_back(m_pc);
`endif
      end else if (dec_ready && instr_valid) begin
        m_pc = m_pc + 4;
        exp_q.push_back(m_pc);
      end
    end
  end
  // in-order memory with per-request random latency
  initial begin
    logic [31:0] pa[$];
    int pd[$];
    int cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        pa.delete();
        pd.delete();
      end else if (imem_req) begin
        pa.push_back(imem_addr);
        pd.push_back(cyc + $urandom_range(lat_max, lat_min) - 1);
      end
      #1;
      if (pa.size() != 0 && pd[0] <= cyc) begin
        imem_rvalid = 1;
        imem_rdata = mem(pa.pop_front());
        void'(pd.pop_front());
      end else begin
        imem_rvalid = 0;
        imem_rdata = $urandom;
      end
    end
  end
  // monitor: compare every presented instruction and request against the model
  initial begin
    bit prev_valid = 0;
    logic [31:0] e, d, h_instr, h_pc;
    forever begin
      @(negedge clk);
      if (rst) prev_valid = 0;
      else begin
        chk("fetch_err", {31'b0, fetch_err}, {31'b0, m_fault});
        if (imem_req) begin
          chk("req_addr", imem_addr, m_pc);
          chk("req_while_valid", {31'b0, instr_valid}, 0);
          chk("req_in_fault", {31'b0, imem_req & m_fault}, 0);
        end
        if (instr_valid && !prev_valid) begin
          if (exp_q.size() == 0) chk("unexpected_valid", {31'b0, instr_valid}, 0);
          else begin
            e = exp_q.pop_front();
            d = mem(e);
            chk("pc_out", pc_out, e);
            chk("instr", instr, d);
            chk("instr_op", {26'b0, instr_op}, {26'b0, d[31:26]});
            chk("pc_plus4", pc_plus4, e + 4);
          end
          h_instr = instr;
          h_pc = pc_out;
        end else if (instr_valid) begin
          chk("hold_instr", instr, h_instr);
          chk("hold_pc", pc_out, h_pc);
        end
        prev_valid = instr_valid;
      end
    end
  end
  task automatic wait_valid(input string name);
    int n = 0;
    while (!instr_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk(name, {31'b0, instr_valid}, 1);
  endtask
  initial begin
    int n;
    bit saw;
    repeat (3) @(negedge clk);
    chk("rst_req", {31'b0, imem_req}, 0);
    chk("rst_valid", {31'b0, instr_valid}, 0);
    chk("rst_instr", instr, 0);
    chk("rst_err", {31'b0, fetch_err}, 0);
    rst = 0;
    @(negedge clk);
    chk("first_req", {31'b0, imem_req}, 1);
    chk("first_addr", imem_addr, 0);
    @(negedge clk);
    chk("wait_no_valid", {31'b0, instr_valid}, 0);
    @(negedge clk);
    chk("first_valid_c3", {31'b0, instr_valid}, 1);
    chk("first_op", {26'b0, instr_op}, 32'h23);
    chk("first_pc_plus4", pc_plus4, 4);
    repeat (5) begin
      @(negedge clk);
      chk("stall_valid", {31'b0, instr_valid}, 1);
      chk("stall_no_req", {31'b0, imem_req}, 0);
      chk("stall_instr", instr, 32'h8C22_0004);
    end
    lat_min = 3;
    lat_max = 3;
    dec_ready = 1;
    @(negedge clk);
    dec_ready = 0;
    chk("next_req", {31'b0, imem_req}, 1);
    chk("next_addr", imem_addr, 4);
    @(negedge clk);
    redirect = 1;
    redirect_pc = 32'h40;
    @(negedge clk);
    redirect = 0;
    n = 0;
    saw = 0;
    while (!imem_req && n < 20) begin
      if (instr_valid) saw = 1;
      @(negedge clk);
      n++;
    end
    chk("squash_no_valid", {31'b0, saw}, 0);
    chk("squash_req", {31'b0, imem_req}, 1);
    chk("squash_addr", imem_addr, 32'h40);
    wait_valid("valid_40");
    chk("pc_40", pc_out, 32'h40);
    redirect = 1;
    dec_ready = 1;
    redirect_pc = 32'h100;
    @(negedge clk);
    redirect = 0;
    dec_ready = 0;
    chk("hold_redir_valid1", {31'b0, instr_valid}, 0);
    chk("hold_redir_addr", imem_addr, 32'h100);
    @(negedge clk);
    chk("hold_redir_valid2", {31'b0, instr_valid}, 0);
    wait_valid("valid_100");
    redirect = 1;
    redirect_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    redirect = 0;
    wait_valid("valid_top");
    chk("pc_top", pc_out, 32'hFFFF_FFFC);
    chk("plus4_wrap", pc_plus4, 0);
    dec_ready = 1;
    @(negedge clk);
    dec_ready = 0;
    chk("wrap_req", {31'b0, imem_req}, 1);
    chk("wrap_addr", imem_addr, 0);
    wait_valid("valid_wrap");
    redirect = 1;
    redirect_pc = 32'h102;
    @(negedge clk);
    redirect = 0;
`ifdef IFETCH_ALIGN_CHECK_EN
    chk("misalign_err", {31'b0, fetch_err}, 1);
    repeat (8) begin
      @(negedge clk);
      chk("fault_no_req", {31'b0, imem_req | instr_valid}, 0);
    end
`else
    chk("misalign_req", {31'b0, imem_req}, 1);
    chk("misalign_addr", imem_addr, 32'h100);
`endif
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    lat_min = 1;
    lat_max = 4;
    for (int i = 0; i < 3000; i++) begin
      dec_ready = ($urandom % 4) != 0;
      redirect = ($urandom % 10) == 0;
      case ($urandom % 4)
        0: redirect_pc = $urandom % 32'h200;
        1: redirect_pc = 32'hFFFF_FFF0 | ($urandom % 16);
        default: redirect_pc = $urandom;
      endcase
`ifdef IFETCH_ALIGN_CHECK_EN
      redirect_pc[1:0] = 2'b00;
`endif
      @(negedge clk);
    end
    redirect = 0;
    dec_ready = 0;
    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Instruction-fetch stage directly upstream of the main decoder/control unit.
- Holds the PC, requests instruction words from a variable-latency instruction memory, and presents one instruction at a time to decode.
- `instr_op` feeds the control unit's opcode input directly.
- Accepts branch/jump redirects computed downstream (`branch & zero` → target) and squashes any in-flight fetch.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; first address fetched.
- ADDR_W, 32, PC and memory address width; PC increments by 4 modulo 2^ADDR_W.

Ports:
- clk, input, 1, single clock; all state updates on rising edge.
- rst, input, 1, synchronous, active-high reset.
- imem_req, output, 1, one-cycle read strobe to instruction memory.
- imem_addr, output, ADDR_W, read address; valid while imem_req=1.
- imem_rdata, input, 32, instruction word; sampled only when imem_rvalid=1.
- imem_rvalid, input, 1, read data valid; earliest 1 cycle after imem_req, any latency allowed.
- redirect, input, 1, branch/jump taken; one-cycle pulse.
- redirect_pc, input, ADDR_W, target PC; sampled when redirect=1.
- dec_ready, input, 1, decode consumes the presented instruction this cycle.
- instr_valid, output, 1, instr/pc_out hold a valid instruction.
- instr, output, 32, registered instruction word.
- instr_op, output, 6, instr[31:26], combinational from the instr register.
- pc_out, output, ADDR_W, PC of the presented instruction.
- pc_plus4, output, ADDR_W, pc_out + 4, combinational.
- fetch_err, output, 1, sticky misaligned-redirect flag (see optional feature).

Behaviour:
- Reset (rst=1 at an edge):
  - pc ← RESET_PC; state ← IDLE; squash ← 0.
  - instr ← 0; instr_valid ← 0; imem_req ← 0; fetch_err ← 0.
  - Applies from any state. An outstanding memory response after reset is ignored unless it arrives in WAIT.
- FSM states: IDLE, REQ, WAIT, HOLD (plus FAULT with the optional feature).
  - IDLE: no request. Moves to REQ the cycle after rst deasserts.
  - REQ: imem_req=1 and imem_addr=pc for exactly one cycle, then WAIT.
  - WAIT: imem_req=0. On imem_rvalid with squash=0: instr ← imem_rdata, instr_valid ← 1, pc_out ← pc, → HOLD. On imem_rvalid with squash=1: discard data, squash ← 0, → REQ.
  - HOLD: instr_valid=1, instr stable. On dec_ready: pc ← pc+4, instr_valid ← 0, → REQ.
- Redirect handling (redirect has priority over dec_ready and imem_rvalid in the same cycle):
  - IDLE: pc ← redirect_pc; stays on the normal path to REQ.
  - REQ: pc ← redirect_pc; squash ← 1; → WAIT (the issued request is discarded).
  - WAIT, no rvalid: pc ← redirect_pc; squash ← 1.
  - WAIT, rvalid same cycle: discard data, pc ← redirect_pc, → REQ.
  - HOLD: pc ← redirect_pc; instr_valid ← 0 next cycle; → REQ. The held instruction is never consumed, even if dec_ready=1.
- imem_rvalid outside WAIT is ignored.
- PC arithmetic is unsigned, width ADDR_W, and wraps: pc=FFFF_FFFC + 4 → 0000_0000.
- Throughput: with 1-cycle memory latency, one instruction per 3 cycles (REQ, WAIT, HOLD, with dec_ready=1 in HOLD).
- First instr_valid: 1-cycle memory, rst deasserted at cycle 0 → REQ at cycle 1, rvalid at cycle 2, instr_valid=1 at cycle 3.

Optional Feature:
- Macro: IFETCH_ALIGN_CHECK_EN.
- Defined:
  - redirect with redirect_pc[1:0]≠0 sets fetch_err ← 1 (sticky), drops instr_valid, and enters FAULT.
  - FAULT issues no requests and ignores all inputs until rst.
- Undefined:
  - redirect_pc[1:0] forced to 2'b00 when loaded.
  - fetch_err tied 0; no FAULT state.

Test Plan:
- Reset, 1-cycle mem returning 32'h8C22_0004 at 0x0 → imem_addr=0x0, instr_valid=1 at cycle 3, instr_op=6'b100011, pc_plus4=0x4.
- Hold dec_ready=0 for 5 cycles in HOLD → instr/pc_out stable, no new imem_req; dec_ready=1 → next imem_req addr=0x4.
- 3-cycle mem latency with redirect to 0x40 during WAIT → first rvalid data discarded, next imem_req addr=0x40, instr_valid only for the 0x40 word.
- Redirect to 0x100 in the same cycle as dec_ready=1 in HOLD → next request 0x100 (not pc+4), instr_valid low for ≥2 cycles.
- RESET_PC=32'hFFFF_FFFC, consume one instruction → next imem_addr=0x0000_0000.
- With IFETCH_ALIGN_CHECK_EN, redirect_pc=0x102 → fetch_err=1 next cycle, imem_req stays 0 until rst; without the macro → fetch from 0x100.
